// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop synchronised rx, mid-bit sampling, one-cycle
// valid / framing_error strobes and a busy flag covering the whole frame.
module uart_receiver #(
  parameter int BAUD_RATE    = 9_600,
  parameter int SYS_CLK_FREQ = 48_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       framing_error,
  output logic       busy
);

  localparam int BIT_PERIOD  = SYS_CLK_FREQ / BAUD_RATE;
  localparam int HALF_PERIOD = BIT_PERIOD / 2;
  localparam int TIMER_W     = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;

  localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(BIT_PERIOD - 1);
  localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t             state;
  logic               rx_meta;
  logic               rx_s;
  logic [TIMER_W-1:0] timer;
  logic [2:0]         bit_index;
  logic [7:0]         shift_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b0;
      rx_s    <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Strobes default low every cycle; busy is registered alongside the state
  // so it falls on the same edge that raises valid or framing_error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= WAIT_HIGH;
      timer         <= '0;
      bit_index     <= '0;
      shift_reg     <= '0;
      data_out      <= '0;
      valid         <= 1'b0;
      framing_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      valid         <= 1'b0;
      framing_error <= 1'b0;
      case (state)
        WAIT_HIGH: begin
          if (rx_s) state <= IDLE;
        end
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            timer <= HALF_LAST;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (timer == '0) begin
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state     <= DATA;
              bit_index <= '0;
              timer     <= BIT_LAST;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        DATA: begin
          if (timer == '0) begin
            shift_reg <= {rx_s, shift_reg[7:1]};
            timer     <= BIT_LAST;
            if (bit_index == 3'd7) state <= STOP;
            else                   bit_index <= bit_index + 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        STOP: begin
          if (timer == '0) begin
            busy <= 1'b0;
            // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
            if (rx_s) begin
              data_out <= shift_reg;
              valid    <= 1'b1;
              state    <= IDLE;
            end else begin
              framing_error <= 1'b1;
              state         <= WAIT_HIGH;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          state <= WAIT_HIGH;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
